ex_stage: RTL and testbench

Execute stage and EX/MEM pipeline register for the five-stage RISC-V core. It consumes the ID/EX register outputs: operand values, 4-bit ALU control, destination register and MEM/WB control. It computes the ALU result, with an iterative multiplier for MUL, and registers the result with control for the MEM stage. While a multiply is in flight it raises `stall_o` so that IF/ID and ID/EX hold their contents.

---
 rtl/ex_pkg.sv | 18 +
 rtl/ex_stage_if.sv | 26 ++
 rtl/ex_stage_iter_mul.sv | 56 +++++
 rtl/ex_stage.sv | 59 +++++
 tb/tb_ex_stage.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: shared ALU opcodes, multiplier state encoding and EX/MEM payload type
package ex_pkg;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b1111;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
    logic [1:0]  mem;
    logic        wb;
  } exmem_t;
  localparam exmem_t EXMEM_BUBBLE = '0;
endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX inputs, stall and EX/MEM outputs of the execute stage
interface ex_stage_if;
  logic        valid_i;
  logic [31:0] val1_i;
  logic [31:0] val2_i;
  logic [31:0] store_data_i;
  logic [3:0]  alu_ctrl_i;
  logic [4:0]  rd_addr_i;
  logic [1:0]  mem_i;
  logic        wb_i;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] alu_result_o;
  logic [31:0] store_data_o;
  logic [4:0]  rd_addr_o;
  logic [1:0]  mem_o;
  logic        wb_o;
  modport master (
    output valid_i, val1_i, val2_i, store_data_i, alu_ctrl_i, rd_addr_i, mem_i, wb_i,
    input  stall_o, valid_o, alu_result_o, store_data_o, rd_addr_o, mem_o, wb_o
  );
  modport slave (
    input  valid_i, val1_i, val2_i, store_data_i, alu_ctrl_i, rd_addr_i, mem_i, wb_i,
    output stall_o, valid_o, alu_result_o, store_data_o, rd_addr_o, mem_o, wb_o
  );
endinterface

// File: rtl/ex_stage_iter_mul.sv
// iter_mul: shift-add multiplier retiring MUL_STEP multiplier bits per busy cycle
module iter_mul import ex_pkg::*; #(
  parameter int MUL_STEP = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);
  localparam int K = 32 / MUL_STEP;
  mul_state_t  state, next;
  logic [31:0] acc, mcand, mplier, pp;
  logic [5:0]  count;
  assign busy    = state == BUSY;
  assign done    = state == DONE;
  assign product = acc;
  // sum of the partial products for the low MUL_STEP multiplier bits
  always_comb begin
    pp = '0;
    for (int j = 0; j < MUL_STEP; j++) pp = pp + (mplier[j] ? mcand << j : 32'd0);
  end
  // next state: a start in IDLE runs K busy cycles, then one DONE cycle
  always_comb begin
    next = state;
    next = state == IDLE ? (start ? BUSY : IDLE) :
           state == BUSY ? (count == 6'(K - 1) ? DONE : BUSY) : IDLE;
  end
  // state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else state <= next;
  end
  // operand load on start, accumulate and shift while busy
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (state == IDLE && start) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      count  <= '0;
    end else if (busy) begin
      acc    <= acc + pp;
      mcand  <= mcand << MUL_STEP;
      mplier <= mplier >> MUL_STEP;
      count  <= count + 6'd1;
    end
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: ALU, optional iterative multiplier (EX_ITER_MUL_EN) and EX/MEM register
module ex_stage import ex_pkg::*; #(
  parameter int MUL_STEP = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  ex_stage_if.slave  bus
);
  logic [31:0] a, b, alu_res, mul_res;
  logic        mul_op, stall_int, done;
  exmem_t      q, nxt;
  if (!(MUL_STEP == 1 || MUL_STEP == 2 || MUL_STEP == 4 || MUL_STEP == 8)) begin : g_bad_step
    $error("MUL_STEP must be 1, 2, 4 or 8");
  end
  assign a      = bus.val1_i;
  assign b      = bus.val2_i;
  assign mul_op = bus.alu_ctrl_i == ALU_MUL;
`ifdef EX_ITER_MUL_EN
  logic busy;
  iter_mul #(.MUL_STEP(MUL_STEP)) u_mul (
    .clk_i,
    .rst_i,
    .start   (bus.valid_i && mul_op),
    .a,
    .b,
    .busy,
    .done,
    .product (mul_res)
  );
  assign stall_int = busy || (bus.valid_i && mul_op && !done);
`else
  assign mul_res   = a * b;
  assign stall_int = 1'b0;
  assign done      = 1'b0;
`endif
  assign bus.stall_o = rst_i && stall_int;
  // ALU select and EX/MEM next value: product on DONE, bubble while stalled or idle
  always_comb begin
    alu_res = bus.alu_ctrl_i == ALU_ADD ? a + b :
              bus.alu_ctrl_i == ALU_SUB ? a - b :
              bus.alu_ctrl_i == ALU_AND ? a & b :
              bus.alu_ctrl_i == ALU_OR  ? a | b :
              mul_op                    ? mul_res : 32'd0;
    nxt = done ? {1'b1, mul_res, bus.store_data_i, bus.rd_addr_i, bus.mem_i, bus.wb_i} :
          (!bus.valid_i || stall_int) ? EXMEM_BUBBLE :
          {1'b1, alu_res, bus.store_data_i, bus.rd_addr_i, bus.mem_i, bus.wb_i};
  end
  // EX/MEM pipeline register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) q <= EXMEM_BUBBLE;
    else q <= nxt;
  end
  assign bus.valid_o      = q.valid;
  assign bus.alu_result_o = q.result;
  assign bus.store_data_o = q.store_data;
  assign bus.rd_addr_o    = q.rd_addr;
  assign bus.mem_o        = q.mem;
  assign bus.wb_o         = q.wb;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed bench for ex_stage with MUL_STEP=1 and MUL_STEP=4 instances
module tb_ex_stage;
  import ex_pkg::*;
`ifdef EX_ITER_MUL_EN
  localparam bit ITER = 1'b1;
`else
  localparam bit ITER = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst;
  logic        valid, wb;
  logic [31:0] v1, v2, sd;
  logic [3:0]  op;
  logic [4:0]  rd;
  logic [1:0]  mem;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  ex_stage_if if1 ();
  ex_stage_if if4 ();
  assign if1.valid_i = valid;
  assign if1.val1_i = v1;
  assign if1.val2_i = v2;
  assign if1.store_data_i = sd;
  assign if1.alu_ctrl_i = op;
  assign if1.rd_addr_i = rd;
  assign if1.mem_i = mem;
  assign if1.wb_i = wb;
  assign if4.valid_i = valid;
  assign if4.val1_i = v1;
  assign if4.val2_i = v2;
  assign if4.store_data_i = sd;
  assign if4.alu_ctrl_i = op;
  assign if4.rd_addr_i = rd;
  assign if4.mem_i = mem;
  assign if4.wb_i = wb;
  ex_stage #(.MUL_STEP(1)) u1 (.clk_i(clk), .rst_i(rst), .bus(if1.slave));
  ex_stage #(.MUL_STEP(4)) u4 (.clk_i(clk), .rst_i(rst), .bus(if4.slave));

  task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int k_of(input int d);
    return d == 0 ? 32 : 8;
  endfunction

  function automatic logic [31:0] alu(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      ALU_ADD: return x + y;
      ALU_SUB: return x - y;
      ALU_AND: return x & y;
      ALU_OR:  return x | y;
      ALU_MUL: return x * y;
      default: return 32'd0;
    endcase
  endfunction

  // Model: ph counts cycles since a multiply was accepted (1..K busy, K+1 done)
  int          ph [2];
  logic [31:0] ma [2];
  logic [31:0] mb [2];
  logic [72:0] ex [2];
  always @(posedge clk or negedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        ph[d] <= 0;
        ex[d] <= '0;
      end else if (ITER && ph[d] == 0 && valid && op == ALU_MUL) begin
        ph[d] <= 1;
        ma[d] <= v1;
        mb[d] <= v2;
        ex[d] <= '0;
      end else if (ph[d] >= 1 && ph[d] <= k_of(d)) begin
        ph[d] <= ph[d] + 1;
        ex[d] <= '0;
      end else if (ph[d] == k_of(d) + 1) begin
        ph[d] <= 0;
        ex[d] <= {1'b1, ma[d] * mb[d], sd, rd, mem, wb};
      end else begin
        ex[d] <= valid ? {1'b1, alu(op, v1, v2), sd, rd, mem, wb} : 73'd0;
      end
    end
  end

  function automatic logic exp_stall(input int d);
    return rst && ITER && ((ph[d] == 0 && valid && op == ALU_MUL) || (ph[d] >= 1 && ph[d] <= k_of(d)));
  endfunction

  function automatic logic [72:0] act_out(input int d);
    return d == 0 ? {if1.valid_o, if1.alu_result_o, if1.store_data_o, if1.rd_addr_o, if1.mem_o, if1.wb_o}
                  : {if4.valid_o, if4.alu_result_o, if4.store_data_o, if4.rd_addr_o, if4.mem_o, if4.wb_o};
  endfunction

  // Compare both instances against the model every cycle
  always @(negedge clk) begin
    chk("stall_step1", 73'(if1.stall_o), 73'(exp_stall(0)));
    chk("stall_step4", 73'(if4.stall_o), 73'(exp_stall(1)));
    chk("exmem_step1", act_out(0), ex[0]);
    chk("exmem_step4", act_out(1), ex[1]);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vl, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input logic [1:0] m, input logic w);
    valid = vl;
    op    = o;
    v1    = a;
    v2    = b;
    sd    = ~a;
    rd    = r;
    mem   = m;
    wb    = w;
  endtask

  // Wait for the step-1 multiply to finish, then check stall lengths and products
  task automatic wait_mul(input logic [31:0] expv, input bit chk4);
    int n1, n4;
    logic [31:0] r4;
    logic v4;
    bit got4;
    n1 = -1;
    n4 = -1;
    got4 = 1'b0;
    r4 = '0;
    v4 = 1'b0;
    for (int c = 0; c < 200 && n1 < 0; c++) begin
      @(negedge clk);
      if (n4 >= 0 && !got4 && c == n4 + 1) begin
        r4 = if4.alu_result_o;
        v4 = if4.valid_o;
        got4 = 1'b1;
      end
      if (n4 < 0 && !if4.stall_o) n4 = c;
      if (!if1.stall_o) n1 = c;
    end
    if (n1 < 0) chk("mul_timeout", 73'd0, 73'd1);
    @(posedge clk);
    #1;
    if (!got4) begin
      r4 = if4.alu_result_o;
      v4 = if4.valid_o;
    end
    chk("mul_stall_cycles", 73'(n1), ITER ? 73'd33 : 73'd0);
    chk("mul_result", 73'(if1.alu_result_o), 73'(expv));
    chk("mul_valid", 73'(if1.valid_o), 73'd1);
    if (chk4) begin
      chk("mul4_stall_cycles", 73'(n4), ITER ? 73'd9 : 73'd0);
      chk("mul4_result", 73'(r4), 73'(expv));
      chk("mul4_valid", 73'(v4), 73'd1);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, ALU_MUL, 32'hFFFF_0001, 32'h1234_5678, 5'd31, 2'd3, 1'b1);
    #2 rst = 1'b0;
    cyc();
    cyc();
    chk("rst_outs1", act_out(0), 73'd0);
    chk("rst_outs4", act_out(1), 73'd0);
    chk("rst_stall", 73'(if1.stall_o), 73'd0);
    drive(1'b1, ALU_ADD, 32'd5, 32'd7, 5'd3, 2'd0, 1'b1);
    rst = 1'b1;
    cyc();
    chk("add_result", 73'(if1.alu_result_o), 73'd12);
    chk("add_rd", 73'(if1.rd_addr_o), 73'd3);
    chk("add_wb", 73'(if1.wb_o), 73'd1);
    chk("add_valid", 73'(if1.valid_o), 73'd1);
    chk("add_result4", 73'(if4.alu_result_o), 73'd12);
    drive(1'b1, ALU_SUB, 32'd3, 32'd5, 5'd4, 2'd0, 1'b1);
    cyc();
    chk("sub_result", 73'(if1.alu_result_o), 73'h0_FFFF_FFFE);
    drive(1'b1, ALU_AND, 32'h0000_F0F0, 32'h0000_0FF0, 5'd5, 2'd1, 1'b0);
    cyc();
    chk("and_result", 73'(if1.alu_result_o), 73'h0_0000_00F0);
    chk("and_mem", 73'(if1.mem_o), 73'd1);
    drive(1'b1, ALU_OR, 32'h0000_F000, 32'h0000_000F, 5'd6, 2'd0, 1'b1);
    cyc();
    chk("or_result", 73'(if1.alu_result_o), 73'h0_0000_F00F);
    drive(1'b1, 4'b0101, 32'd9, 32'd10, 5'd9, 2'd2, 1'b1);
    cyc();
    chk("undef_result", 73'(if1.alu_result_o), 73'd0);
    chk("undef_rd", 73'(if1.rd_addr_o), 73'd9);
    chk("undef_mem", 73'(if1.mem_o), 73'd2);
    chk("undef_valid", 73'(if1.valid_o), 73'd1);
    drive(1'b0, ALU_ADD, 32'd1, 32'd2, 5'd12, 2'd3, 1'b1);
    cyc();
    chk("bubble_outs", act_out(0), 73'd0);
    drive(1'b1, ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 2'd0, 1'b1);
    wait_mul(32'd1, 1'b1);
    drive(1'b1, ALU_MUL, 32'd6, 32'd7, 5'd8, 2'd0, 1'b1);
    wait_mul(32'd42, 1'b0);
    drive(1'b1, ALU_MUL, 32'h0001_0000, 32'h0001_0000, 5'd10, 2'd0, 1'b1);
    wait_mul(32'd0, 1'b0);
    drive(1'b1, ALU_MUL, 32'h0000_1234, 32'h0000_5678, 5'd11, 2'd0, 1'b1);
    for (int i = 0; i < 10; i++) cyc();
    rst = 1'b0;
    #1;
    chk("midrst_outs1", act_out(0), 73'd0);
    chk("midrst_outs4", act_out(1), 73'd0);
    chk("midrst_stall", 73'(if1.stall_o), 73'd0);
    cyc();
    rst = 1'b1;
    wait_mul(32'h0626_0060, 1'b1);
    drive(1'b1, ALU_MUL, 32'd1000, 32'd1000, 5'd13, 2'd1, 1'b1);
    wait_mul(32'd1000000, 1'b0);
    for (int i = 0; i < 12; i++) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
